ship_bullet_gen: RTL and testbench

Pixel generation stage directly downstream of the VGA sync generator in the space shooter display path. Consumes `pixel_x`, `pixel_y`, `video_on` and `p_tick`, and owns the player ship's horizontal position and a single-bullet state machine. Both update once per frame. Drives a registered 3-bit `rgb` value per pixel and exports bullet state for later collision logic.

---
 rtl/ship_bullet_gen.sv | 132 +++++++++++++
 tb/tb_ship_bullet_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ship_bullet_gen.sv
// Pixel generation stage after the VGA sync generator: player ship, single bullet
// FSM and registered colour output. Position and bullet state move once per frame.
module ship_bullet_gen #(
  parameter int          SHIP_Y     = 448,
  parameter int          SHIP_V     = 4,
  parameter int          BULLET_V   = 8,
  parameter logic [2:0]  SHIP_RGB   = 3'b010,
  parameter logic [2:0]  BULLET_RGB = 3'b110,
  parameter logic [2:0]  BG_RGB     = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fire,
  output logic [2:0] rgb,
  output logic       bullet_active,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       shot_fired
);

  typedef enum logic {IDLE, FLY} state_t;

  localparam logic [10:0] SHIP_MAX  = 11'd624;
  localparam logic [9:0]  SHIP_INIT = 10'd312;
  localparam logic [10:0] SHIP_TOP  = 11'(SHIP_Y);
  localparam logic [9:0]  LAUNCH_Y  = 10'(SHIP_Y - 8);

  state_t      state;
  logic [9:0]  ship_x;
  logic [9:0]  ship_next;
  logic        fire_d;
  logic        fire_pend;
  logic        fire_edge;
  logic        fire_req;
  logic        refr_tick;
  logic [10:0] ship_wide;
  logic [10:0] ship_plus;
  logic [10:0] px;
  logic [10:0] py;
  logic [10:0] bx;
  logic [10:0] by;
  logic        in_ship;
  logic        in_bullet;

  assign refr_tick     = p_tick && (pixel_y == 10'd480) && (pixel_x == 10'd0);
  assign fire_edge     = btn_fire & ~fire_d;
  assign fire_req      = fire_pend | fire_edge;
  assign bullet_active = (state == FLY);

  assign ship_wide = {1'b0, ship_x};
  assign ship_plus = ship_wide + 11'(SHIP_V);
  assign px        = {1'b0, pixel_x};
  assign py        = {1'b0, pixel_y};
  assign bx        = {1'b0, bullet_x};
  assign by        = {1'b0, bullet_y};

  // Widened to 11 bits so the right-edge sum cannot wrap past 1023.
  always_comb begin
    ship_next = ship_x;
    if (btn_left && !btn_right)
      ship_next = (ship_wide >= 11'(SHIP_V)) ? ship_x - 10'(SHIP_V) : 10'd0;
    else if (btn_right && !btn_left)
      ship_next = (ship_plus <= SHIP_MAX) ? ship_plus[9:0] : SHIP_MAX[9:0];
  end

  assign in_ship   = (px >= ship_wide) && (px < ship_wide + 11'd16) &&
                     (py >= SHIP_TOP)  && (py < SHIP_TOP + 11'd16);
  assign in_bullet = bullet_active &&
                     (px >= bx) && (px < bx + 11'd2) &&
                     (py >= by) && (py < by + 11'd8);

  // Launch reads ship_x before this tick's move, so the bullet leaves the old nose.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ship_x     <= SHIP_INIT;
      fire_d     <= 1'b0;
      fire_pend  <= 1'b0;
      bullet_x   <= 10'd0;
      bullet_y   <= 10'd0;
      shot_fired <= 1'b0;
    end else begin
      fire_d     <= btn_fire;
      shot_fired <= 1'b0;
      if (refr_tick) begin
        fire_pend <= 1'b0;
        ship_x    <= ship_next;
        case (state)
          IDLE: begin
            if (fire_req) begin
              bullet_x   <= ship_x + 10'd7;
              bullet_y   <= LAUNCH_Y;
              shot_fired <= 1'b1;
              state      <= FLY;
            end
          end
          FLY: begin
            if (bullet_y < 10'(BULLET_V))
              state <= IDLE;
            else
              bullet_y <= bullet_y - 10'(BULLET_V);
          end
          default: state <= IDLE;
        endcase
      end else if (fire_edge) begin
        fire_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb <= 3'b000;
    end else if (p_tick) begin
      if (!video_on)
        rgb <= 3'b000;
      else if (in_bullet)
        rgb <= BULLET_RGB;
      else if (in_ship)
        rgb <= SHIP_RGB;
      else
        rgb <= BG_RGB;
    end
  end

endmodule

// File: tb/tb_ship_bullet_gen.sv
// Bench for ship_bullet_gen: frame-level reference model checked every clk,
// plus directed vectors with hand-computed values.
module tb_ship_bullet_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       p_tick = 1'b0;
  logic       video_on = 1'b0;
  logic [9:0] pixel_x = 10'd0;
  logic [9:0] pixel_y = 10'd0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_fire = 1'b0;
  logic [2:0] rgb;
  logic       bullet_active;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;
  logic       shot_fired;

  int total = 0;
  int bad = 0;
  logic last_shot = 1'b0;

  // Reference model state, described in screen terms.
  int   m_ship = 312;
  bit   m_active = 0;
  int   m_bx = 0;
  int   m_by = 0;
  bit   m_shot = 0;
  bit   m_pend = 0;
  bit   m_prev_fire = 0;
  logic [2:0] m_rgb = 3'b000;

  ship_bullet_gen dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire),
    .rgb(rgb), .bullet_active(bullet_active), .bullet_x(bullet_x),
    .bullet_y(bullet_y), .shot_fired(shot_fired)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [10:0] act, input logic [10:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] colour_at(int x, int y, bit von);
    if (!von) return 3'b000;
    if (m_active && x >= m_bx && x < m_bx + 2 && y >= m_by && y < m_by + 8) return 3'b110;
    if (x >= m_ship && x < m_ship + 16 && y >= 448 && y < 464) return 3'b010;
    return 3'b000;
  endfunction

  // Model: colour is taken from the sprites as they stand before the frame move.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ship = 312; m_active = 0; m_bx = 0; m_by = 0;
      m_shot = 0; m_pend = 0; m_prev_fire = 0; m_rgb = 3'b000;
    end else begin
      bit rise;
      rise = btn_fire && !m_prev_fire;
      m_shot = 0;
      if (p_tick) m_rgb = colour_at(int'(pixel_x), int'(pixel_y), video_on);
      if (p_tick && pixel_x == 10'd0 && pixel_y == 10'd480) begin
        if (m_active) begin
          if (m_by < 8) m_active = 0;
          else m_by = m_by - 8;
        end else if (m_pend || rise) begin
          m_active = 1; m_bx = m_ship + 7; m_by = 440; m_shot = 1;
        end
        if (btn_left && !btn_right) m_ship = (m_ship - 4 < 0) ? 0 : m_ship - 4;
        else if (btn_right && !btn_left) m_ship = (m_ship + 4 > 624) ? 624 : m_ship + 4;
        m_pend = 0;
      end else if (rise) begin
        m_pend = 1;
      end
      m_prev_fire = btn_fire;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      checkOutput("rgb", 11'(rgb), 11'(m_rgb));
      checkOutput("bullet_active", 11'(bullet_active), 11'(m_active));
      checkOutput("bullet_x", 11'(bullet_x), 11'(m_bx));
      checkOutput("bullet_y", 11'(bullet_y), 11'(m_by));
      checkOutput("shot_fired", 11'(shot_fired), 11'(m_shot));
      checkOutput("ship_x", 11'(dut.ship_x), 11'(m_ship));
    end
  end

  // One pixel slot: p_tick for one clk, then three idle clks.
  task automatic applyStimulus(input int x, input int y, input bit von);
    @(negedge clk);
    p_tick = 1'b1; pixel_x = 10'(x); pixel_y = 10'(y); video_on = von;
    @(negedge clk);
    last_shot = shot_fired;
    p_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame();
    applyStimulus(0, 480, 0);
  endtask

  task automatic pulse_fire();
    @(negedge clk); btn_fire = 1'b1;
    @(negedge clk); btn_fire = 1'b0;
  endtask

  initial begin
    int shots;
    repeat (10) @(negedge clk);
    checkOutput("reset rgb", 11'(rgb), 11'd0);
    checkOutput("reset ship_x", 11'(dut.ship_x), 11'd312);
    checkOutput("reset active", 11'(bullet_active), 11'd0);
    checkOutput("reset bullet_y", 11'(bullet_y), 11'd0);
    checkOutput("reset shot", 11'(shot_fired), 11'd0);
    reset = 1'b1;
    run_frame();
    applyStimulus(320, 450, 1);
    checkOutput("ship pixel", 11'(rgb), 11'd2);
    applyStimulus(327, 463, 1); checkOutput("ship corner", 11'(rgb), 11'd2);
    applyStimulus(328, 450, 1); checkOutput("right of ship", 11'(rgb), 11'd0);
    applyStimulus(311, 450, 1); checkOutput("left of ship", 11'(rgb), 11'd0);
    applyStimulus(320, 464, 1); checkOutput("below ship", 11'(rgb), 11'd0);
    applyStimulus(320, 450, 0); checkOutput("blanked ship", 11'(rgb), 11'd0);

    // Row 480 without p_tick, or at column 1, must not count as a frame.
    btn_left = 1'b1;
    @(negedge clk); pixel_x = 10'd0; pixel_y = 10'd480; video_on = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(1, 480, 0);
    checkOutput("no false tick", 11'(dut.ship_x), 11'd312);

    for (int k = 1; k <= 80; k++) begin
      run_frame();
      if (k == 1) checkOutput("left step", 11'(dut.ship_x), 11'd308);
      if (k == 78) checkOutput("left reach 0", 11'(dut.ship_x), 11'd0);
    end
    checkOutput("left clamp", 11'(dut.ship_x), 11'd0);
    btn_right = 1'b1;
    run_frame();
    checkOutput("both hold", 11'(dut.ship_x), 11'd0);
    btn_left = 1'b0;
    repeat (155) run_frame();
    checkOutput("right to 620", 11'(dut.ship_x), 11'd620);
    run_frame();
    checkOutput("right clamp", 11'(dut.ship_x), 11'd624);
    run_frame();
    checkOutput("right stays", 11'(dut.ship_x), 11'd624);
    btn_right = 1'b0; btn_left = 1'b1;
    repeat (78) run_frame();
    btn_left = 1'b0;
    checkOutput("back to 312", 11'(dut.ship_x), 11'd312);

    pulse_fire();
    applyStimulus(319, 440, 1);
    checkOutput("pre-launch bg", 11'(rgb), 11'd0);
    run_frame();
    checkOutput("launch shot", 11'(last_shot), 11'd1);
    checkOutput("launch bx", 11'(bullet_x), 11'd319);
    checkOutput("launch by", 11'(bullet_y), 11'd440);
    checkOutput("launch active", 11'(bullet_active), 11'd1);
    applyStimulus(319, 440, 1); checkOutput("bullet top-left", 11'(rgb), 11'd6);
    applyStimulus(320, 447, 1); checkOutput("bullet bottom-right", 11'(rgb), 11'd6);
    applyStimulus(321, 440, 1); checkOutput("right of bullet", 11'(rgb), 11'd0);
    applyStimulus(318, 440, 1); checkOutput("left of bullet", 11'(rgb), 11'd0);
    applyStimulus(319, 439, 1); checkOutput("above bullet", 11'(rgb), 11'd0);
    applyStimulus(319, 448, 1); checkOutput("ship under bullet", 11'(rgb), 11'd2);
    applyStimulus(319, 440, 0); checkOutput("blanked bullet", 11'(rgb), 11'd0);

    pulse_fire();
    run_frame();
    checkOutput("no relaunch", 11'(last_shot), 11'd0);
    checkOutput("fly step", 11'(bullet_y), 11'd432);
    repeat (54) run_frame();
    checkOutput("top by", 11'(bullet_y), 11'd0);
    checkOutput("top active", 11'(bullet_active), 11'd1);
    run_frame();
    checkOutput("dead active", 11'(bullet_active), 11'd0);
    checkOutput("dead by hold", 11'(bullet_y), 11'd0);
    checkOutput("dead bx hold", 11'(bullet_x), 11'd319);
    run_frame();
    checkOutput("no queued launch", 11'(bullet_active), 11'd0);

    @(negedge clk); btn_fire = 1'b1;
    run_frame();
    checkOutput("held launch", 11'(last_shot), 11'd1);
    shots = 0;
    for (int k = 0; k < 58; k++) begin
      run_frame();
      shots += int'(last_shot);
    end
    btn_fire = 1'b0;
    checkOutput("held single shot", 11'(shots), 11'd0);
    checkOutput("held dead", 11'(bullet_active), 11'd0);

    pulse_fire();
    run_frame();
    repeat (30) run_frame();
    checkOutput("mid by", 11'(bullet_y), 11'd200);
    applyStimulus(319, 200, 1);
    checkOutput("mid bullet pixel", 11'(rgb), 11'd6);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("async rgb", 11'(rgb), 11'd0);
    checkOutput("async active", 11'(bullet_active), 11'd0);
    checkOutput("async by", 11'(bullet_y), 11'd0);
    checkOutput("async bx", 11'(bullet_x), 11'd0);
    @(negedge clk); reset = 1'b1;
    run_frame();
    checkOutput("post reset idle", 11'(bullet_active), 11'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
